// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between the caches, the block arbiter and the backing memory
//
// Purpose: groups the icache, dcache and memory handshake/data signals of mem_arbiter.
// Modports:
//   slave  - arbiter view: takes cache requests and mem_rdata; drives done/rdata,
//            the memory strobes/address/write block and busy.
//   master - cache/memory-model view, the mirror image of slave.
// Signals:
//   ic_req, ic_addr, ic_done, ic_rdata                 icache fill channel
//   dc_req, dc_rd, dc_addr, dc_wb, dc_wb_addr,
//   dc_wb_data, dc_done, dc_rdata                      dcache fill/writeback channel
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata     backing memory
//   busy                                               arbiter not idle

interface mem_arbiter_if #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 256
);

  logic               ic_req;
  logic [WORD_W-1:0]  ic_addr;
  logic               ic_done;
  logic [BLOCK_W-1:0] ic_rdata;

  logic               dc_req;
  logic               dc_rd;
  logic [WORD_W-1:0]  dc_addr;
  logic               dc_wb;
  logic [WORD_W-1:0]  dc_wb_addr;
  logic [BLOCK_W-1:0] dc_wb_data;
  logic               dc_done;
  logic [BLOCK_W-1:0] dc_rdata;

  logic [WORD_W-1:0]  mem_addr;
  logic               mem_rd;
  logic               mem_wr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;

  logic               busy;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_rd, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
    input  mem_rdata,
    output ic_done, ic_rdata,
    output dc_done, dc_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    output busy
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_rd, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
    output mem_rdata,
    input  ic_done, ic_rdata,
    input  dc_done, dc_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one block memory between the icache and dcache
//
// Purpose: accepts icache fills and dcache fill/writeback requests, grants one,
// and sequences it against a fixed-latency memory: optional writeback first,
// then optional fill, then a one-cycle done pulse to the granted cache.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any transaction, no done pulse
//   bus    mem_arbiter_if.slave: cache request/done/rdata channels, memory
//          strobes/address/data, busy
// Parameters: WORD_W (address width), BLOCK_W (line width), MEM_LATENCY (>=1).
// Configuration macro: ARB_RR_EN
//   defined   - round-robin: on a tie, grant the requester not served last
//   undefined - fixed priority, dcache over icache

module mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_W     = 256,
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  // Clears the byte-offset bits of a line address (offset = log2(BLOCK_W/8) bits).
  localparam logic [WORD_W-1:0] ALIGN_MASK = ~(WORD_W'(BLOCK_W / 8) - WORD_W'(1));

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_ISSUE,
    S_WB_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_dc_q, grant_dc_d;   // 1 = dcache owns the transaction
  logic               last_dc_q, last_dc_d;     // last completed grant, 0 = icache
  logic               need_rd_q, need_rd_d;
  logic [WORD_W-1:0]  fill_addr_q, fill_addr_d;
  logic [WORD_W-1:0]  wb_addr_q, wb_addr_d;
  logic [BLOCK_W-1:0] wb_data_q, wb_data_d;
  logic [BLOCK_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [BLOCK_W-1:0] dc_rdata_q, dc_rdata_d;

  logic               pick_dc;

  logic               ic_done_o;
  logic               dc_done_o;
  logic [WORD_W-1:0]  mem_addr_o;
  logic               mem_rd_o;
  logic               mem_wr_o;
  logic [BLOCK_W-1:0] mem_wdata_o;
  logic               busy_o;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      grant_dc_q  <= 1'b0;
      last_dc_q   <= 1'b0;
      need_rd_q   <= 1'b0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_dc_q  <= grant_dc_d;
      last_dc_q   <= last_dc_d;
      need_rd_q   <= need_rd_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_dc_d  = grant_dc_q;
    last_dc_d   = last_dc_q;
    need_rd_d   = need_rd_q;
    fill_addr_d = fill_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;

    // On a tie the dcache wins unless round-robin is on and it was served last.
    pick_dc = bus.dc_req && (!bus.ic_req || !RR_EN || !last_dc_q);

    case (state_q)
      S_IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          grant_dc_d = pick_dc;
          wb_addr_d  = bus.dc_wb_addr;
          wb_data_d  = bus.dc_wb_data;
          if (pick_dc) begin
            fill_addr_d = bus.dc_addr;
            need_rd_d   = bus.dc_rd;
            if (bus.dc_wb) begin
              state_d = S_WB_ISSUE;
            end else if (bus.dc_rd) begin
              state_d = S_RD_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            fill_addr_d = bus.ic_addr;
            need_rd_d   = 1'b1;
            state_d     = S_RD_ISSUE;
          end
        end
      end

      S_WB_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WB_WAIT;
      end

      S_WB_WAIT: begin
        if (cnt_q == '0) begin
          state_d = need_rd_q ? S_RD_ISSUE : S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RD_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        // mem_rdata is only guaranteed in the last wait cycle.
        if (cnt_q == '0) begin
          if (grant_dc_q) begin
            dc_rdata_d = bus.mem_rdata;
          end else begin
            ic_rdata_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        last_dc_d = grant_dc_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode purely from registered state so reset clears them at once.
  always_comb begin
    ic_done_o   = 1'b0;
    dc_done_o   = 1'b0;
    mem_addr_o  = '0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_wdata_o = '0;
    busy_o      = (state_q != S_IDLE);

    case (state_q)
      S_WB_ISSUE: begin
        mem_wr_o    = 1'b1;
        mem_addr_o  = wb_addr_q & ALIGN_MASK;
        mem_wdata_o = wb_data_q;
      end
      S_RD_ISSUE: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = fill_addr_q & ALIGN_MASK;
      end
      S_DONE: begin
        ic_done_o = !grant_dc_q;
        dc_done_o = grant_dc_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.ic_done   = ic_done_o;
  assign bus.dc_done   = dc_done_o;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.mem_addr  = mem_addr_o;
  assign bus.mem_rd    = mem_rd_o;
  assign bus.mem_wr    = mem_wr_o;
  assign bus.mem_wdata = mem_wdata_o;
  assign bus.busy      = busy_o;

endmodule
